pc_next_unit: RTL and testbench
===============================

// Module: pc_next_unit
// PURPOSE
//   Program-counter register and next-PC selection for the single-cycle RV32I core.
//   Consumes branch_taken from the branch condition unit, plus jump controls from the decoder.
//   Produces the fetch PC for the next instruction and detects misaligned control-transfer targets.
//   On a misaligned target it redirects to a trap vector through a one-cycle bubble.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC loaded on reset
//   TRAP_VEC  32'h0000_0100  PC loaded on misaligned-target trap
// PORTS
//   clk           in   1   core clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   stall         in   1   hold PC and state this cycle
//   branch_taken  in   1   conditional branch resolved taken
//   jump          in   1   JAL
//   jalr          in   1   JALR
//   imm           in   32  sign-extended B/J/I immediate
//   rs1_data      in   32  rs1 operand for JALR
//   pc            out  32  current fetch PC (registered)
//   pc_plus4      out  32  pc + 4, for JAL/JALR link write
//   pc_valid      out  1   instruction at pc may commit; 0 = bubble, suppress RF/mem writes
//   misalign_exc  out  1   registered pulse: trap taken this cycle
//   mepc          out  32  PC of the last faulting control-transfer instruction
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - pc=RESET_PC, mepc=0, misalign_exc=0, pc_valid=0, state=BOOT.
//   Targets, computed combinationally from the current pc (32-bit wrap, no overflow flag):
//   - br_tgt = pc + imm.
//   - jalr_tgt = (rs1_data + imm) & ~32'h1.
//   - pc_plus4 = pc + 4; wraps 32'hFFFF_FFFC -> 0.
//   Next-PC select in RUN, priority high to low:
//   - jalr -> jalr_tgt.
//   - jump -> br_tgt.
//   - branch_taken -> br_tgt.
//   - otherwise pc_plus4.
//   - Simultaneous controls resolve by that priority; no error is raised.
//   - Misaligned = selected target is a redirect (jalr|jump|branch_taken) and target[1:0]!=0.
//   States:
//   - BOOT: pc_valid=0. Next cycle -> RUN with pc unchanged (RESET_PC). Ignores stall and all controls.
//   - RUN: pc_valid=1.
//     - stall=1: pc, mepc and state hold; misaligned is not evaluated.
//     - stall=0 and aligned: pc <= selected target; stay in RUN.
//     - stall=0 and misaligned: mepc <= pc; pc <= TRAP_VEC; -> TRAP.
//   - TRAP: pc=TRAP_VEC, pc_valid=0, misalign_exc=1. Next cycle -> RUN unconditionally; stall and controls are ignored.
//   - misalign_exc=1 only while in TRAP, so it is exactly one cycle wide.
//   - A stall never extends BOOT or TRAP.
//   - Reset mid-trap: returns to BOOT immediately; mepc is cleared.
//   Latency:
//   - A redirect decided in cycle N gives the new pc in cycle N+1.
//   - A trap gives pc=TRAP_VEC in N+1 as a bubble; the handler commits from N+2.
// CONFIGURATION
//   PC_RETIRE_CNT_EN defined:
//   - Adds output retire_cnt [63:0].
//   - Reset value 0.
//   - Increments on each clk edge where state==RUN, pc_valid=1 and stall=0 (faulting instruction included).
//   - Wraps at 2^64.
//   PC_RETIRE_CNT_EN undefined:
//   - The port and the counter are absent; all other behaviour is identical.
// TESTING
//   1 Reset: release rst_n -> pc=0, pc_valid=0 for 1 cycle, then pc=0 with pc_valid=1, then 4, 8, 12.
//   2 Branch: pc=0x40, imm=0xFFFF_FFF0, branch_taken=1 -> pc=0x30 next cycle; branch_taken=0 -> pc=0x44.
//   3 JALR: rs1_data=0x1003, imm=0x2 -> pc=0x1004; jalr=1 and jump=1 together -> JALR target wins.
//   4 Misalign: pc=0x80, jump=1, imm=0x6 ->
//     - N+1: pc=0x100, misalign_exc=1, pc_valid=0, mepc=0x80.
//     - N+2: pc=0x100, pc_valid=1, misalign_exc=0.
//   5 Stall: stall=1 for 3 cycles with branch_taken=1 and imm=0x2 -> pc holds, no trap; then stall=0 -> trap taken.
//   6 Retire counter (PC_RETIRE_CNT_EN): 10 RUN cycles with 2 stalled -> retire_cnt=8.
//     - BOOT and TRAP cycles add 0; async reset mid-count -> 0.

Source files
------------

// File: rtl/pc_next_unit_if.sv
// Fetch-side bus of the PC unit: decoder/branch controls in, fetch PC and trap status out.
// PC_RETIRE_CNT_EN adds the retire_cnt observation signal.
interface pc_next_unit_if;
    logic        stall;
    logic        branch_taken;
    logic        jump;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        misalign_exc;
    logic [31:0] mepc;
`ifdef PC_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    modport master (
        output stall, branch_taken, jump, jalr, imm, rs1_data,
`ifdef PC_RETIRE_CNT_EN
        input  retire_cnt,
`endif
        input  pc, pc_plus4, pc_valid, misalign_exc, mepc
    );

    modport slave (
        input  stall, branch_taken, jump, jalr, imm, rs1_data,
`ifdef PC_RETIRE_CNT_EN
        output retire_cnt,
`endif
        output pc, pc_plus4, pc_valid, misalign_exc, mepc
    );
endinterface

// File: rtl/pc_next_unit.sv
// PC register and next-PC select for the single-cycle RV32I core, with misaligned-target trap.
// Optional retired-instruction counter enabled by defining PC_RETIRE_CNT_EN.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input logic          clk,
    input logic          rst_n,
    pc_next_unit_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] mepc_q, mepc_nxt;
    logic [31:0] br_tgt, jalr_tgt, seq_pc, sel_tgt;
    logic        redirect, misaligned;

    assign br_tgt   = pc_q + bus.imm;
    assign jalr_tgt = (bus.rs1_data + bus.imm) & ~32'h1;
    assign seq_pc   = pc_q + 32'd4;
    assign redirect = bus.jalr | bus.jump | bus.branch_taken;

    always_comb begin
        sel_tgt = seq_pc;
        if (bus.jalr)
            sel_tgt = jalr_tgt;
        else if (bus.jump || bus.branch_taken)
            sel_tgt = br_tgt;
    end

    // Sequential fall-through is always word aligned, so only redirects can fault.
    assign misaligned = redirect && (sel_tgt[1:0] != 2'b00);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        mepc_nxt  = mepc_q;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (!bus.stall) begin
                    if (misaligned) begin
                        mepc_nxt  = pc_q;
                        pc_nxt    = TRAP_VEC;
                        state_nxt = TRAP;
                    end else begin
                        pc_nxt = sel_tgt;
                    end
                end
            end
            TRAP:    state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BOOT;
            pc_q   <= RESET_PC;
            mepc_q <= 32'h0;
        end else begin
            state  <= state_nxt;
            pc_q   <= pc_nxt;
            mepc_q <= mepc_nxt;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = seq_pc;
    assign bus.pc_valid     = (state == RUN);
    assign bus.misalign_exc = (state == TRAP);
    assign bus.mepc         = mepc_q;

`ifdef PC_RETIRE_CNT_EN
    logic [63:0] retire_q;

    // The faulting instruction still counts as retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_q <= 64'h0;
        else if (state == RUN && !bus.stall)
            retire_q <= retire_q + 64'd1;
    end

    assign bus.retire_cnt = retire_q;
`endif
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit: reset, branch, JALR, trap, stall, retire counter.
module tb_pc_next_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pc_next_unit_if bus ();

    pc_next_unit #(
        .RESET_PC (32'h0000_0000),
        .TRAP_VEC (32'h0000_0100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall = 0; bus.branch_taken = 0; bus.jump = 0; bus.jalr = 0;
        bus.imm = 32'h0; bus.rs1_data = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b0 || bus.mepc !== 32'h0 || bus.misalign_exc !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: pc=%h valid=%b mepc=%h exc=%b, want 0/0/0/0", bus.pc, bus.pc_valid, bus.mepc, bus.misalign_exc);
        end
        rst_n = 1;
        #1;
        checks++;
        if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b0) begin
            failures++;
            $display("FAIL boot_bubble: pc=%h valid=%b, want 0/0", bus.pc, bus.pc_valid);
        end
        tick();
        checks++;
        if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b1) begin
            failures++;
            $display("FAIL boot_to_run: pc=%h valid=%b, want 0/1", bus.pc, bus.pc_valid);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (bus.pc !== 32'(4 * i) || bus.pc_valid !== 1'b1) begin
                failures++;
                $display("FAIL seq_pc%0d: pc=%h valid=%b, want %h/1", i, bus.pc, bus.pc_valid, 32'(4 * i));
            end
        end
    endtask

    task automatic test_branch();
        // pc=0x0C, JAL +0x34 -> 0x40
        bus.jump = 1; bus.imm = 32'h34;
        tick();
        checks++;
        if (bus.pc !== 32'h40) begin
            failures++;
            $display("FAIL jal_to_40: pc=%h, want 00000040", bus.pc);
        end
        idle();
        bus.branch_taken = 1; bus.imm = 32'hFFFF_FFF0;
        tick();
        checks++;
        if (bus.pc !== 32'h30 || bus.pc_plus4 !== 32'h34) begin
            failures++;
            $display("FAIL branch_back: pc=%h plus4=%h, want 00000030/00000034", bus.pc, bus.pc_plus4);
        end
        idle();
        bus.jump = 1; bus.imm = 32'h10;
        tick();
        idle();
        bus.imm = 32'hFFFF_FFF0;
        tick();
        checks++;
        if (bus.pc !== 32'h44) begin
            failures++;
            $display("FAIL branch_not_taken: pc=%h, want 00000044", bus.pc);
        end
        idle();
        bus.jalr = 1; bus.rs1_data = 32'hFFFF_FFFC;
        tick();
        checks++;
        if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0) begin
            failures++;
            $display("FAIL plus4_wrap: pc=%h plus4=%h, want fffffffc/00000000", bus.pc, bus.pc_plus4);
        end
        idle();
        tick();
        checks++;
        if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b1) begin
            failures++;
            $display("FAIL pc_wrap: pc=%h valid=%b, want 00000000/1", bus.pc, bus.pc_valid);
        end
    endtask

    task automatic test_jalr();
        bus.jalr = 1; bus.rs1_data = 32'h1003; bus.imm = 32'h2;
        tick();
        checks++;
        if (bus.pc !== 32'h1004) begin
            failures++;
            $display("FAIL jalr_lsb_clear: pc=%h, want 00001004", bus.pc);
        end
        // JAL would go to 0x100C, JALR to 0x2008
        bus.jalr = 1; bus.jump = 1; bus.branch_taken = 1; bus.rs1_data = 32'h2000; bus.imm = 32'h8;
        tick();
        checks++;
        if (bus.pc !== 32'h2008 || bus.misalign_exc !== 1'b0) begin
            failures++;
            $display("FAIL jalr_priority: pc=%h exc=%b, want 00002008/0", bus.pc, bus.misalign_exc);
        end
        idle();
        bus.jump = 1; bus.branch_taken = 1; bus.imm = 32'h20;
        tick();
        checks++;
        if (bus.pc !== 32'h2028) begin
            failures++;
            $display("FAIL jal_over_branch: pc=%h, want 00002028", bus.pc);
        end
        idle();
    endtask

    task automatic test_misalign();
        bus.jalr = 1; bus.rs1_data = 32'h80;
        tick();
        idle();
        bus.jump = 1; bus.imm = 32'h6;
        tick();
        // controls held during TRAP must be ignored
        bus.stall = 1; bus.jump = 1; bus.imm = 32'h40;
        checks++;
        if (bus.pc !== 32'h100 || bus.misalign_exc !== 1'b1 || bus.pc_valid !== 1'b0 || bus.mepc !== 32'h80) begin
            failures++;
            $display("FAIL trap_entry: pc=%h exc=%b valid=%b mepc=%h, want 00000100/1/0/00000080", bus.pc, bus.misalign_exc, bus.pc_valid, bus.mepc);
        end
        tick();
        idle();
        checks++;
        if (bus.pc !== 32'h100 || bus.misalign_exc !== 1'b0 || bus.pc_valid !== 1'b1) begin
            failures++;
            $display("FAIL trap_exit: pc=%h exc=%b valid=%b, want 00000100/0/1", bus.pc, bus.misalign_exc, bus.pc_valid);
        end
    endtask

    task automatic test_stall();
        bus.jalr = 1; bus.rs1_data = 32'h200;
        tick();
        idle();
        bus.stall = 1; bus.branch_taken = 1; bus.imm = 32'h2;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.pc !== 32'h200 || bus.misalign_exc !== 1'b0 || bus.pc_valid !== 1'b1 || bus.mepc !== 32'h80) begin
                failures++;
                $display("FAIL stall_hold%0d: pc=%h exc=%b valid=%b mepc=%h, want 00000200/0/1/00000080", i, bus.pc, bus.misalign_exc, bus.pc_valid, bus.mepc);
            end
        end
        bus.stall = 0;
        tick();
        idle();
        checks++;
        if (bus.pc !== 32'h100 || bus.misalign_exc !== 1'b1 || bus.mepc !== 32'h200) begin
            failures++;
            $display("FAIL stall_release_trap: pc=%h exc=%b mepc=%h, want 00000100/1/00000200", bus.pc, bus.misalign_exc, bus.mepc);
        end
        // Reset mid-trap: asynchronous, takes effect without a clock edge
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (bus.pc !== 32'h0 || bus.mepc !== 32'h0 || bus.misalign_exc !== 1'b0 || bus.pc_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_trap: pc=%h mepc=%h exc=%b valid=%b, want 0/0/0/0", bus.pc, bus.mepc, bus.misalign_exc, bus.pc_valid);
        end
        tick();
        rst_n = 1;
        tick();
        checks++;
        if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_run: pc=%h valid=%b, want 0/1", bus.pc, bus.pc_valid);
        end
    endtask

`ifdef PC_RETIRE_CNT_EN
    task automatic test_retire_cnt();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        checks++;
        if (bus.retire_cnt !== 64'd0) begin
            failures++;
            $display("FAIL retire_boot: cnt=%0d, want 0", bus.retire_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            bus.stall = (i == 3 || i == 6);
            tick();
        end
        bus.stall = 0;
        checks++;
        if (bus.retire_cnt !== 64'd8) begin
            failures++;
            $display("FAIL retire_10_2stall: cnt=%0d, want 8", bus.retire_cnt);
        end
        bus.jump = 1; bus.imm = 32'h2;
        tick();
        idle();
        tick();
        checks++;
        if (bus.retire_cnt !== 64'd9) begin
            failures++;
            $display("FAIL retire_trap: cnt=%0d, want 9", bus.retire_cnt);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (bus.retire_cnt !== 64'd0) begin
            failures++;
            $display("FAIL retire_reset: cnt=%0d, want 0", bus.retire_cnt);
        end
        tick();
        rst_n = 1;
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 0;
        test_reset();
        test_branch();
        test_jalr();
        test_misalign();
        test_stall();
`ifdef PC_RETIRE_CNT_EN
        test_retire_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
